score_counter: RTL and testbench

- Downstream consumer of the top-level game state: counts score while the game runs and drives the board's 4-digit seven-segment display.
- Samples `game_status` and the VGA `vs` frame strobe.
- Advances a 4-digit BCD score once every FRAMES_PER_POINT frames.
- Latches a high score when a run ends; multiplexes the digits onto active-low segment and anode lines.

---
 rtl/score_counter_pkg.sv | 53 +++++
 rtl/score_counter_seg7_decode.sv | 26 ++
 rtl/score_counter.sv | 111 +++++++++++
 tb/tb_score_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/score_counter_pkg.sv
// Shared constants and BCD helpers for the score counter and its seven-segment decoder.
package score_counter_pkg;

   localparam int          DIGIT_W       = 4;
   localparam logic [15:0] MAX_SCORE_BCD = 16'h9999;

   // Active-low {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
               r[i*DIGIT_W +: DIGIT_W] = 4'd0;
            end else begin
               r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // First differing digit, most significant first, decides the order.
   function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
      logic gt;
      logic done;
      gt   = 1'b0;
      done = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (!done && (a[i*DIGIT_W +: DIGIT_W] != b[i*DIGIT_W +: DIGIT_W])) begin
            gt   = a[i*DIGIT_W +: DIGIT_W] > b[i*DIGIT_W +: DIGIT_W];
            done = 1'b1;
         end
      end
      return gt;
   endfunction

endpackage

// File: rtl/score_counter_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern; non-BCD codes blank.
module seg7_decode
   import score_counter_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [7:0]         seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_counter.sv
// Frame-paced BCD score counter with 4-digit multiplexed seven-segment output.
// High-score storage and the show_high mux exist only when SCORE_HISCORE_EN is defined.
module score_counter
   import score_counter_pkg::*;
#(
   parameter int FRAMES_PER_POINT = 6,
   parameter int SCAN_DIV_BITS    = 17
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        fresh,
   input  logic        game_status,
   input  logic        show_high,
   output logic [15:0] score_bcd,
   output logic [15:0] high_bcd,
   output logic [7:0]  seg,
   output logic [3:0]  an
);

   logic                     fresh_q;
   logic                     status_q;
   logic [7:0]               frame_cnt;
   logic [SCAN_DIV_BITS-1:0] scan_cnt;
   logic [1:0]               idx;

   logic        tick, run_start, run_end;
   logic [15:0] disp_bcd;
   logic [3:0]  sel_digit;
   logic        blank;
   logic [7:0]  dec_seg;

   // vs falling edge marks the start of vertical blanking
   assign tick      = fresh_q & ~fresh;
   assign run_start = game_status & ~status_q;
   assign run_end   = ~game_status & status_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fresh_q   <= 1'b0;
         status_q  <= 1'b0;
         frame_cnt <= 8'd0;
         score_bcd <= 16'h0000;
      end else begin
         fresh_q  <= fresh;
         status_q <= game_status;
         if (run_start) begin
            frame_cnt <= 8'd0;
            score_bcd <= 16'h0000;
         end else if (game_status && tick) begin
            if (frame_cnt == 8'(FRAMES_PER_POINT - 1)) begin
               frame_cnt <= 8'd0;
               if (score_bcd != MAX_SCORE_BCD) score_bcd <= bcd_inc(score_bcd);
            end else begin
               frame_cnt <= frame_cnt + 8'd1;
            end
         end
      end
   end

`ifdef SCORE_HISCORE_EN
   always_ff @(posedge CLK) begin
      if (RESET) high_bcd <= 16'h0000;
      else if (run_end && bcd_gt(score_bcd, high_bcd)) high_bcd <= score_bcd;
   end
   assign disp_bcd = show_high ? high_bcd : score_bcd;
`else
   logic unused_hiscore;
   assign unused_hiscore = show_high ^ run_end;
   assign high_bcd       = 16'h0000;
   assign disp_bcd       = score_bcd;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
         if (&scan_cnt) idx <= idx + 2'd1;
      end
   end

   assign sel_digit = disp_bcd[{idx, 2'b00} +: DIGIT_W];

   // A digit is blanked while it and every higher digit are zero; ones always shows.
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd3: blank = (disp_bcd[15:12] == 4'd0);
         2'd2: blank = (disp_bcd[15:8]  == 8'd0);
         2'd1: blank = (disp_bcd[15:4]  == 12'd0);
         default: blank = 1'b0;
      endcase
   end

   seg7_decode u_dec (
      .digit (sel_digit),
      .seg   (dec_seg)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         seg <= SEG_BLANK;
         an  <= 4'hF;
      end else begin
         seg <= blank ? SEG_BLANK : dec_seg;
         an  <= ~(4'b0001 << idx);
      end
   end

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter (FRAMES_PER_POINT=2, SCAN_DIV_BITS=3); adapts high-score expectations to SCORE_HISCORE_EN.
module tb_score_counter;

`ifdef SCORE_HISCORE_EN
   localparam bit HI_EN = 1'b1;
`else
   localparam bit HI_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        fresh = 1'b0;
   logic        game_status = 1'b0;
   logic        show_high = 1'b0;
   logic [15:0] score_bcd, high_bcd;
   logic [7:0]  seg;
   logic [3:0]  an;

   int n_vec = 0;
   int n_err = 0;

   score_counter #(.FRAMES_PER_POINT(2), .SCAN_DIV_BITS(3)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .fresh       (fresh),
      .game_status (game_status),
      .show_high   (show_high),
      .score_bcd   (score_bcd),
      .high_bcd    (high_bcd),
      .seg         (seg),
      .an          (an)
   );

   always #5 CLK = ~CLK;

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         fresh = 1'b1;
         cyc();
         fresh = 1'b0;
         cyc();
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] next_an(input logic [3:0] a);
      case (a)
         4'hE: return 4'hD;
         4'hD: return 4'hB;
         4'hB: return 4'h7;
         default: return 4'hE;
      endcase
   endfunction

   // Watch 40 cycles of scanning: each anode must carry its expected pattern, in E,D,B,7 order.
   task automatic scan_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
      logic [3:0] prev;
      prev = an;
      for (int c = 0; c < 40; c++) begin
         cyc();
         if (an !== prev) check({tag, "_an_seq"}, {12'h0, an}, {12'h0, next_an(prev)});
         prev = an;
         case (an)
            4'hE: check({tag, "_d0"}, {8'h0, seg}, {8'h0, e0});
            4'hD: check({tag, "_d1"}, {8'h0, seg}, {8'h0, e1});
            4'hB: check({tag, "_d2"}, {8'h0, seg}, {8'h0, e2});
            4'h7: check({tag, "_d3"}, {8'h0, seg}, {8'h0, e3});
            default: check({tag, "_an_onehot"}, {12'h0, an}, 16'h000E);
         endcase
      end
   endtask

   initial begin
      // Reset state
      cyc();
      check("rst_score", score_bcd, 16'h0000);
      check("rst_high", high_bcd, 16'h0000);
      check("rst_an", {12'h0, an}, 16'h000F);
      check("rst_seg", {8'h0, seg}, 16'h00FF);
      RESET = 1'b0;
      cyc();
      check("scan0_an", {12'h0, an}, 16'h000E);
      check("scan0_seg", {8'h0, seg}, 16'h00C0);

      // Counting: one point per two ticks
      game_status = 1'b1;
      cyc();
      ticks(1);
      check("cnt_1tick", score_bcd, 16'h0000);
      ticks(1);
      check("cnt_2tick", score_bcd, 16'h0001);
      ticks(18);
      check("cnt_20tick", score_bcd, 16'h0010);
      ticks(178);
      check("cnt_0099", score_bcd, 16'h0099);
      ticks(2);
      check("carry_0100", score_bcd, 16'h0100);
      ticks(19798);
      check("reach_9999", score_bcd, 16'h9999);
      ticks(4);
      check("sat_9999", score_bcd, 16'h9999);

      // Reset while running clears everything
      RESET = 1'b1;
      game_status = 1'b0;
      cyc();
      check("rst2_score", score_bcd, 16'h0000);
      check("rst2_high", high_bcd, 16'h0000);
      RESET = 1'b0;
      cyc();

      // Run 1 -> 0015, high latches
      game_status = 1'b1;
      cyc();
      ticks(30);
      check("run1_score", score_bcd, 16'h0015);
      game_status = 1'b0;
      cyc();
      check("run1_high", high_bcd, HI_EN ? 16'h0015 : 16'h0000);
      ticks(4);
      check("stopped_frozen", score_bcd, 16'h0015);

      // Run 2 -> 0007, high unchanged
      game_status = 1'b1;
      cyc();
      check("run2_start", score_bcd, 16'h0000);
      ticks(14);
      check("run2_score", score_bcd, 16'h0007);
      game_status = 1'b0;
      cyc();
      check("run2_high", high_bcd, HI_EN ? 16'h0015 : 16'h0000);

      // Run 3 -> 0050, high raised
      game_status = 1'b1;
      cyc();
      check("run3_start", score_bcd, 16'h0000);
      ticks(100);
      game_status = 1'b0;
      cyc();
      check("run3_high", high_bcd, HI_EN ? 16'h0050 : 16'h0000);

      // Run 4 to 0030, then reset mid-run
      game_status = 1'b1;
      cyc();
      ticks(60);
      check("run4_score", score_bcd, 16'h0030);
      RESET = 1'b1;
      cyc();
      check("midrst_score", score_bcd, 16'h0000);
      check("midrst_high", high_bcd, 16'h0000);
      check("midrst_an", {12'h0, an}, 16'h000F);
      check("midrst_seg", {8'h0, seg}, 16'h00FF);
      RESET = 1'b0;
      game_status = 1'b0;
      cyc();

      // Display of 0042 with leading-zero blanking
      game_status = 1'b1;
      cyc();
      ticks(84);
      game_status = 1'b0;
      cyc();
      check("disp_score", score_bcd, 16'h0042);
      check("disp_high", high_bcd, HI_EN ? 16'h0042 : 16'h0000);
      cyc(2);
      scan_check("s42", 8'hA4, 8'h99, 8'hFF, 8'hFF);

      // Score 0005 vs high 0042: show_high selects source only when enabled
      game_status = 1'b1;
      cyc();
      ticks(10);
      game_status = 1'b0;
      cyc();
      check("s5_score", score_bcd, 16'h0005);
      check("s5_high", high_bcd, HI_EN ? 16'h0042 : 16'h0000);
      cyc(2);
      scan_check("s5_cur", 8'h92, 8'hFF, 8'hFF, 8'hFF);
      show_high = 1'b1;
      cyc(2);
      if (HI_EN) scan_check("s5_hi", 8'hA4, 8'h99, 8'hFF, 8'hFF);
      else       scan_check("s5_hi", 8'h92, 8'hFF, 8'hFF, 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
